// File: rtl/crypt_pipe_ctrl.sv
// Enable/select sequencer for the pipelined byte-permutation cipher.
// Optional macro CRYPT_CTRL_BUBBLE_SQUEEZE_EN: per-stage advance so bubbles collapse.
module crypt_pipe_ctrl #(
   parameter int NUM_STAGES = 8,
   parameter int KEY_W      = 2*NUM_STAGES,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [KEY_W-1:0]        in_key,
   input  logic                    flush,
   output logic [NUM_STAGES-1:0]   stage_en,
   output logic [2*NUM_STAGES-1:0] stage_sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    flush_done,
   output logic [CNT_W-1:0]        blk_count
);

   localparam int N = NUM_STAGES;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     vld_q, vld_d;
   logic [KEY_W-1:0] key_q [N];
   logic [KEY_W-1:0] key_d [N];
   logic             fd_q, fd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     en;
   logic             accept;

`ifdef CRYPT_CTRL_BUBBLE_SQUEEZE_EN
   // A stage may move whenever it is empty or the stage ahead moves.
   always_comb begin
      en = '0;
      en[N-1] = ~vld_q[N-1] | out_ready;
      for (int i = N-2; i >= 0; i--)
         en[i] = ~vld_q[i] | en[i+1];
   end
`else
   always_comb begin
      en = {N{~vld_q[N-1] | out_ready}};
   end
`endif

   assign in_ready = ~reset & en[0]
                   & (state_q != DRAIN) & ~flush;
   assign accept   = in_valid & in_ready;

   always_comb begin
      vld_d = vld_q;
      for (int i = 0; i < N; i++)
         key_d[i] = key_q[i];
      if (en[0]) begin
         vld_d[0] = accept;
         key_d[0] = accept ? in_key : '0;
      end
      for (int i = 1; i < N; i++) begin
         if (en[i]) begin
            vld_d[i] = vld_q[i-1];
            key_d[i] = key_q[i-1];
         end
      end
   end

   // Each stage selects with the key of the block it is about to capture.
   always_comb begin
      stage_sel      = '0;
      stage_sel[1:0] = in_key[1:0];
      for (int i = 1; i < N; i++)
         stage_sel[2*i +: 2] = key_q[i-1][2*i +: 2];
   end

   always_comb begin
      state_d = state_q;
      fd_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (flush)
               fd_d = 1'b1;
            else if (accept)
               state_d = RUN;
         end
         RUN: begin
            if (flush)
               state_d = DRAIN;
            else if (~|vld_d && !accept)
               state_d = IDLE;
         end
         DRAIN: begin
            if (~|vld_d) begin
               state_d = IDLE;
               fd_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cnt_d = cnt_q + CNT_W'(out_valid & out_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         vld_q   <= '0;
         fd_q    <= 1'b0;
         cnt_q   <= '0;
         for (int i = 0; i < N; i++)
            key_q[i] <= '0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         fd_q    <= fd_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < N; i++)
            key_q[i] <= key_d[i];
      end
   end

   assign stage_en   = reset ? '0 : en;
   assign out_valid  = vld_q[N-1];
   assign busy       = ~reset & ((|vld_q) | (state_q != IDLE));
   assign flush_done = fd_q;
   assign blk_count  = cnt_q;

endmodule
